// File: rtl/picorv_memory.sv
// picorv_memory: PicoRV32-style memory with configurable wait states, byte-strobed writes, fetch counter; optional macro PICORV_MEMORY_WRAP_EN wraps out-of-range indices
module picorv_memory #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_insn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] fetch_count,
  output logic        busy
);
  localparam int AW = $clog2(MEM_WORDS);
`ifdef PICORV_MEMORY_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;
  state_t r_state, w_next;
  logic [29:0] r_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_insn;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [MEM_WORDS];
  logic        w_go, w_src, w_insn, w_hit, w_unused;
  logic [29:0] w_idx;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [AW-1:0] w_waddr;
  assign busy = r_state != IDLE;
  assign w_unused = ^mem_addr[1:0];
  // next state; a zero-latency request uses the live payload, otherwise the captured one
  always_comb begin
    w_next = r_state == IDLE ? (mem_valid ? (LATENCY > 0 ? WAIT : RESP) : IDLE) :
             r_state == WAIT ? (!mem_valid ? IDLE : (r_cnt == 4'd0 ? RESP : WAIT)) :
             r_state == RESP ? GAP : IDLE;
    w_go    = w_next == RESP;
    w_src   = r_state == IDLE;
    w_idx   = w_src ? mem_addr[31:2] : r_idx;
    w_wdata = w_src ? mem_wdata : r_wdata;
    w_wstrb = w_src ? mem_wstrb : r_wstrb;
    w_insn  = w_src ? mem_insn : r_insn;
    w_hit   = WRAP || (w_idx < 30'(MEM_WORDS));
    w_waddr = w_idx[AW-1:0];
  end
  // state register, payload capture, wait counter and registered response
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      r_state   <= w_next;
      mem_ready <= w_go;
      mem_rdata <= (w_go && w_wstrb == 4'd0 && w_hit) ? r_mem[w_waddr] : 32'd0;
      if (w_go && w_insn) fetch_count <= fetch_count + 32'd1;
      if (r_state == IDLE && mem_valid) begin
        r_idx   <= mem_addr[31:2];
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
        r_insn  <= mem_insn;
        r_cnt   <= CNT_INIT;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end
  // byte-strobed write commits on the response edge; reset blocks it and never clears the array
  always_ff @(posedge clock) begin
    if (!reset && w_go && w_hit)
      for (int b = 0; b < 4; b++)
        if (w_wstrb[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_picorv_memory.sv
// tb_picorv_memory: directed checks of picorv_memory across latency and depth configurations
module tb_picorv_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        valid [4], insn [4], ready [4], busy [4];
  logic [31:0] addr [4], wdata [4], rdata [4], fcnt [4];
  logic [3:0]  wstrb [4];
  int tests = 0;
  int fails = 0;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    picorv_memory #(.MEM_WORDS(g == 3 ? 16 : 1024), .LATENCY(g == 1 ? 3 : (g == 2 ? 0 : 1))) u_dut (
      .clock(clk), .reset(rst), .mem_valid(valid[g]), .mem_insn(insn[g]), .mem_addr(addr[g]),
      .mem_wdata(wdata[g]), .mem_wstrb(wstrb[g]), .mem_ready(ready[g]), .mem_rdata(rdata[g]),
      .fetch_count(fcnt[g]), .busy(busy[g]));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic ins, output logic [31:0] rd, output int n);
    valid[k] = 1'b1; insn[k] = ins; addr[k] = a; wdata[k] = d; wstrb[k] = s; n = 0;
    do begin tick(); n++; end while (!ready[k] && n < 20);
    rd = rdata[k];
    valid[k] = 1'b0; insn[k] = 1'b0; wstrb[k] = 4'd0;
    tick();
    chk("ready_width", ready[k], 0);
    chk("rdata_idle", rdata[k], 0);
    tick();
  endtask
  initial begin
    logic [31:0] rd;
    int n, cnt, last, bad;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 0; insn[i] = 0; addr[i] = 0; wdata[i] = 0; wstrb[i] = 0;
    end
    repeat (3) tick();
    chk("rst_ready", ready[0], 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_fcnt", fcnt[0], 0);
    chk("rst_busy", busy[0], 0);
    rst = 1'b0;
    xact(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, n);
    chk("wr_lat", n, 2);
    chk("wr_rdata", rd, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 0, rd, n);
    chk("rd_lat", n, 2);
    chk("rd_data", rd, 32'hDEADBEEF);
    xact(0, 32'h20, 32'h11223344, 4'hF, 0, rd, n);
    xact(0, 32'h20, 32'hAA00BB00, 4'b0101, 0, rd, n);
    xact(0, 32'h20, 32'h0, 4'h0, 0, rd, n);
    chk("strb_0101", rd, 32'h11003300);
    xact(0, 32'h24, 32'h11223344, 4'hF, 0, rd, n);
    xact(0, 32'h24, 32'hAA00BB00, 4'b0011, 0, rd, n);
    xact(0, 32'h24, 32'h0, 4'h0, 0, rd, n);
    chk("strb_0011", rd, 32'h1122BB00);
    xact(1, 32'h30, 32'h12345678, 4'hF, 0, rd, n);
    chk("l3_lat", n, 4);
    valid[1] = 1; addr[1] = 32'h30; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF;
    tick();
    chk("wait_busy", busy[1], 1);
    valid[1] = 0;
    cnt = 0;
    repeat (6) begin tick(); cnt += int'(ready[1]); end
    chk("abort_ready", cnt, 0);
    chk("abort_busy", busy[1], 0);
    xact(1, 32'h30, 32'h0, 4'h0, 0, rd, n);
    chk("abort_keep", rd, 32'h12345678);
    valid[1] = 1; addr[1] = 32'h34; wdata[1] = 32'hA5A5A5A5; wstrb[1] = 4'hF;
    tick();
    addr[1] = 32'h38; wdata[1] = 32'h0; wstrb[1] = 4'h0;
    n = 1;
    do begin tick(); n++; end while (!ready[1] && n < 20);
    chk("held_lat", n, 4);
    chk("held_wr_rdata", rdata[1], 0);
    valid[1] = 0;
    repeat (2) tick();
    xact(1, 32'h34, 32'h0, 4'h0, 0, rd, n);
    chk("held_data", rd, 32'hA5A5A5A5);
    xact(1, 32'h50, 32'h600DF00D, 4'hF, 0, rd, n);
    valid[1] = 1; addr[1] = 32'h50; wdata[1] = 32'hBAADBAAD; wstrb[1] = 4'hF;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", ready[1], 0);
    chk("rst_mid_busy", busy[1], 0);
    rst = 1'b0;
    valid[1] = 0;
    xact(1, 32'h50, 32'h0, 4'h0, 0, rd, n);
    chk("post_rst_lat", n, 4);
    chk("rst_mid_nowrite", rd, 32'h600DF00D);
    chk("fcnt_zero", fcnt[0], 0);
    repeat (3) xact(0, 32'h10, 32'h0, 4'h0, 1, rd, n);
    chk("fetch_data", rd, 32'hDEADBEEF);
    xact(0, 32'h10, 32'h0, 4'h0, 0, rd, n);
    chk("fcnt_three", fcnt[0], 3);
    rst = 1'b1;
    tick();
    chk("fcnt_rst", fcnt[0], 0);
    rst = 1'b0;
    xact(0, 32'h10, 32'h0, 4'h0, 0, rd, n);
    chk("mem_retained", rd, 32'hDEADBEEF);
    xact(3, 32'h0, 32'h77, 4'hF, 0, rd, n);
    xact(3, 32'h40, 32'h5, 4'hF, 0, rd, n);
    chk("oor_wr_lat", n, 2);
`ifdef PICORV_MEMORY_WRAP_EN
    xact(3, 32'h0, 32'h0, 4'h0, 0, rd, n);
    chk("wrap_rd0", rd, 32'h5);
    xact(3, 32'h40, 32'h0, 4'h0, 0, rd, n);
    chk("wrap_rd40", rd, 32'h5);
`else
    xact(3, 32'h40, 32'h0, 4'h0, 0, rd, n);
    chk("oor_rd_lat", n, 2);
    chk("oor_rd", rd, 0);
    xact(3, 32'h0, 32'h0, 4'h0, 0, rd, n);
    chk("oor_keep0", rd, 32'h77);
`endif
    xact(2, 32'h8, 32'h0F0F0F0F, 4'hF, 0, rd, n);
    chk("l0_wr_lat", n, 1);
    xact(2, 32'h8, 32'h0, 4'h0, 0, rd, n);
    chk("l0_rd_lat", n, 1);
    chk("l0_rd_data", rd, 32'h0F0F0F0F);
    valid[2] = 1; addr[2] = 32'h8; wstrb[2] = 4'h0;
    cnt = 0; bad = 0; last = -2;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ready[2]) begin
        cnt++;
        if (i != last + 3) bad++;
        if (rdata[2] !== 32'h0F0F0F0F) bad++;
        last = i;
      end
    end
    chk("l0_pulses", cnt, 4);
    chk("l0_period", bad, 0);
    valid[2] = 0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
